// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor with a direct-mapped BTB.
// The lookup is combinational from the current state. Responses are registered,
// so a prediction arrives one cycle after the request is accepted. A speculative
// global history steers predictions. A committed history follows the ROB and
// restores the speculative copy on a flush.
module branch_predictor_gshare #(
  parameter int PHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 32,
  parameter int HIST_W      = 6,
  parameter int CNT_W       = 2,
  parameter int TAG_W       = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  output logic              pred_rsp_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              flush_in
);
  localparam int PI = $clog2(PHT_ENTRIES);
  localparam int BI = $clog2(BTB_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [PHT_ENTRIES-1:0][CNT_W-1:0] pht_q, pht_d;
  logic [BTB_ENTRIES-1:0]            btb_vld_q, btb_vld_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] btb_tag_q, btb_tag_d;
  logic [BTB_ENTRIES-1:0][31:0]      btb_tgt_q, btb_tgt_d;
  logic [HIST_W-1:0]                 spec_ghr_q, spec_ghr_d;
  logic [HIST_W-1:0]                 com_ghr_q, com_ghr_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic                              hit_q, hit_d;
  logic                              taken_q, taken_d;
  logic [31:0]                       target_q, target_d;
  logic [HIST_W-1:0]                 ghr_q, ghr_d;

  logic [PI-1:0]    p_idx, u_idx;
  logic [BI-1:0]    p_bidx, u_bidx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic             p_hit, p_taken, accept;
  logic [31:0]      p_target;

  // Only the index and tag bits of the update pc matter.
  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc;

  // Prediction lookup reads the pre-update contents of both tables.
  always_comb begin
    p_idx    = pred_pc[PI+1:2] ^ PI'(spec_ghr_q);
    p_bidx   = pred_pc[BI+1:2];
    p_tag    = pred_pc[BI+2+TAG_W-1:BI+2];
    p_hit    = btb_vld_q[p_bidx] && (btb_tag_q[p_bidx] == p_tag);
    p_taken  = p_hit && pht_q[p_idx][CNT_W-1];
    p_target = p_taken ? btb_tgt_q[p_bidx] : (pred_pc + 32'd4);
    u_idx    = upd_pc[PI+1:2] ^ PI'(upd_ghr);
    u_bidx   = upd_pc[BI+1:2];
    u_tag    = upd_pc[BI+2+TAG_W-1:BI+2];
    accept   = rdy_in && pred_req && !flush_in;
  end

  // Next state: the response register, both histories, and the table updates.
  always_comb begin
    pht_d       = pht_q;
    btb_vld_d   = btb_vld_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    spec_ghr_d  = spec_ghr_q;
    com_ghr_d   = com_ghr_q;
    rsp_valid_d = rsp_valid_q;
    hit_d       = hit_q;
    taken_d     = taken_q;
    target_d    = target_q;
    ghr_d       = ghr_q;
    if (rdy_in) begin
      // A flush also drops a pending response because accept is low.
      rsp_valid_d = accept;
      if (accept) begin
        hit_d    = p_hit;
        taken_d  = p_taken;
        target_d = p_target;
        ghr_d    = spec_ghr_q;
      end
      if (upd_valid)
        com_ghr_d = (com_ghr_q << 1) | HIST_W'(upd_taken);
      // The flush restore sees the history with this cycle's commit already applied.
      if (flush_in)
        spec_ghr_d = com_ghr_d;
      else if (accept && p_hit)
        spec_ghr_d = (spec_ghr_q << 1) | HIST_W'(p_taken);
      if (upd_valid) begin
        if (upd_taken) begin
          if (pht_q[u_idx] != CNT_MAX) pht_d[u_idx] = pht_q[u_idx] + CNT_W'(1);
          btb_vld_d[u_bidx] = 1'b1;
          btb_tag_d[u_bidx] = u_tag;
          btb_tgt_d[u_bidx] = upd_target;
        end else if (pht_q[u_idx] != '0) begin
          pht_d[u_idx] = pht_q[u_idx] - CNT_W'(1);
        end
      end
    end
  end

  // State registers. The asynchronous reset also kills an in-flight response.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pht_q       <= {PHT_ENTRIES{CNT_INIT}};
      btb_vld_q   <= '0;
      btb_tag_q   <= '0;
      btb_tgt_q   <= '0;
      spec_ghr_q  <= '0;
      com_ghr_q   <= '0;
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
      ghr_q       <= '0;
    end else begin
      pht_q       <= pht_d;
      btb_vld_q   <= btb_vld_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
      spec_ghr_q  <= spec_ghr_d;
      com_ghr_q   <= com_ghr_d;
      rsp_valid_q <= rsp_valid_d;
      hit_q       <= hit_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      ghr_q       <= ghr_d;
    end
  end

  assign pred_rsp_valid = rsp_valid_q;
  assign pred_hit       = hit_q;
  assign pred_taken     = taken_q;
  assign pred_target    = target_q;
  assign pred_ghr       = ghr_q;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for the gshare predictor. Stimulus feeds a table-level reference model,
// which queues the response each accepted request should produce. A monitor
// compares every fresh response from the DUT against the head of that queue.
module tb_branch_predictor_gshare;
  localparam int PHT = 64, BTB = 32, HW = 6, CW = 2, TW = 8;
  localparam int BI = $clog2(BTB);
  localparam int HMASK = (1 << HW) - 1;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in = 1'b0, rdy_in = 1'b1, pred_req = 1'b0, upd_valid = 1'b0;
  logic          upd_taken = 1'b0, flush_in = 1'b0;
  logic [31:0]   pred_pc = '0, upd_pc = '0, upd_target = '0;
  logic [HW-1:0] upd_ghr = '0;
  logic          pred_rsp_valid, pred_hit, pred_taken;
  logic [31:0]   pred_target;
  logic [HW-1:0] pred_ghr;

  branch_predictor_gshare dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pred_req(pred_req),
    .pred_pc(pred_pc), .pred_rsp_valid(pred_rsp_valid), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush_in(flush_in));

  typedef struct {
    bit          hit;
    bit          taken;
    logic [31:0] tgt;
    int          ghr;
  } exp_t;
  exp_t sb[$];

  // Reference state: counters as plain integers, the BTB as flat arrays.
  int          m_pht[PHT];
  bit          m_bv[BTB];
  int          m_btag[BTB];
  logic [31:0] m_btgt[BTB];
  int          m_spec, m_com;
  int          n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHT; i++) m_pht[i] = (1 << (CW - 1)) - 1;
    for (int i = 0; i < BTB; i++) begin m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = '0; end
    m_spec = 0;
    m_com  = 0;
  endtask

  task automatic m_pred(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] tg);
    int bi, tag, pi;
    bi  = int'((pc >> 2) % BTB);
    tag = int'((pc >> (BI + 2)) % (1 << TW));
    pi  = int'((pc >> 2) % PHT) ^ m_spec;
    h   = m_bv[bi] && (m_btag[bi] == tag);
    t   = h && (m_pht[pi] >= (1 << (CW - 1)));
    tg  = t ? m_btgt[bi] : pc + 32'd4;
  endtask

  // Drive one cycle of inputs, advance the model, then step past the clock edge.
  task automatic cyc(input bit req, input logic [31:0] pc, input bit upd, input logic [31:0] upc,
                     input int ughr, input bit ut, input logic [31:0] utgt, input bit fl, input bit rdy);
    bit h, t;
    logic [31:0] tg;
    int nc, ui, bi;
    pred_req = req; pred_pc = pc; upd_valid = upd; upd_pc = upc; upd_ghr = HW'(ughr);
    upd_taken = ut; upd_target = utgt; flush_in = fl; rdy_in = rdy;
    if (rdy) begin
      m_pred(pc, h, t, tg);
      if (req && !fl) sb.push_back('{h, t, tg, m_spec});
      nc = upd ? (((m_com << 1) | int'(ut)) & HMASK) : m_com;
      if (fl) m_spec = nc;
      else if (req && h) m_spec = ((m_spec << 1) | int'(t)) & HMASK;
      m_com = nc;
      if (upd) begin
        ui = int'((upc >> 2) % PHT) ^ (ughr & HMASK);
        bi = int'((upc >> 2) % BTB);
        if (ut) begin
          if (m_pht[ui] < (1 << CW) - 1) m_pht[ui]++;
          m_bv[bi]   = 1;
          m_btag[bi] = int'((upc >> (BI + 2)) % (1 << TW));
          m_btgt[bi] = utgt;
        end else if (m_pht[ui] > 0) m_pht[ui]--;
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic pred(input logic [31:0] pc);
    cyc(1, pc, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic upd(input logic [31:0] pc, input int g, input bit t, input logic [31:0] tg);
    cyc(0, 0, 1, pc, g, t, tg, 0, 1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    pred_req = 0; upd_valid = 0; flush_in = 0; rdy_in = 1;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", pred_rsp_valid, 0);
    chk("rst_hit", pred_hit, 0);
    chk("rst_taken", pred_taken, 0);
    chk("rst_target", pred_target, 0);
    chk("rst_ghr", pred_ghr, 0);
    rst_in = 1'b1;
  endtask

  // Monitor: a response is fresh only if rdy_in was high at the edge that produced it.
  bit rdy_s = 0;
  always @(posedge clk_in) rdy_s <= rdy_in;
  always @(negedge clk_in) begin
    if (rst_in && rdy_s && pred_rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_spurious: got valid=1 want no response");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_hit", pred_hit, e.hit);
        chk("rsp_taken", pred_taken, e.taken);
        chk("rsp_target", pred_target, e.tgt);
        chk("rsp_ghr", pred_ghr, e.ghr);
      end
    end
  end

  initial begin
    do_reset();
    // First prediction after reset misses; the fall-through pc wraps at the top of memory.
    pred(32'h100);
    chk("miss_valid", pred_rsp_valid, 1);
    chk("miss_hit", pred_hit, 0);
    chk("miss_taken", pred_taken, 0);
    chk("miss_target", pred_target, 32'h104);
    pred(32'hFFFF_FFFC);
    chk("wrap_target", pred_target, 0);
    // Two taken commits train the entry at 0x100.
    upd(32'h100, 0, 1, 32'h80);
    upd(32'h100, 0, 1, 32'h80);
    pred(32'h100);
    chk("train_hit", pred_hit, 1);
    chk("train_taken", pred_taken, 1);
    chk("train_target", pred_target, 32'h80);

    // The counter saturates at 0, and one taken commit only lifts it to 1.
    do_reset();
    repeat (5) upd(32'h200, 0, 0, 0);
    upd(32'h200, 0, 1, 32'h300);
    pred(32'h200);
    chk("sat_hit", pred_hit, 1);
    chk("sat_taken", pred_taken, 0);
    chk("sat_target", pred_target, 32'h204);

    // Three speculative taken predictions, then a flush back to committed history 000001.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      upd(32'h100, 0, 1, 32'h80);
      upd(32'h100, 1, 1, 32'h80);
      upd(32'h100, 3, 1, 32'h80);
    end
    repeat (5) upd(32'h1F0, 0, 0, 0);
    upd(32'h1F0, 0, 1, 32'h900);
    repeat (3) pred(32'h100);
    chk("spec_taken", pred_taken, 1);
    chk("spec_ghr", pred_ghr, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    pred(32'h100);
    chk("flush_ghr", pred_ghr, 1);

    // A prediction and an update to the same entry in one cycle: the prediction sees the old counter.
    do_reset();
    upd(32'h100, 0, 0, 0);
    upd(32'h100, 0, 1, 32'h80);
    cyc(1, 32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 1);
    chk("same_hit", pred_hit, 1);
    chk("same_taken", pred_taken, 0);
    pred(32'h100);
    chk("after_taken", pred_taken, 1);

    // With rdy_in low, requests and updates are ignored.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h100, 1, 32'h100, 0, 1, 32'h500, 1, 0);
      chk("stall_valid", pred_rsp_valid, 0);
    end
    pred(32'h100);
    pred(32'h100);

    // A flush in the same cycle as a request suppresses the response.
    cyc(1, 32'h100, 1, 32'h100, 2, 0, 0, 1, 1);
    chk("flush_suppress", pred_rsp_valid, 0);

    // Reset raised while a response is pending clears it without waiting for a clock edge.
    pred(32'h100);
    #1 rst_in = 1'b0;
    #1 chk("async_abort", pred_rsp_valid, 0);
    sb.delete();
    do_reset();

    // Randomized traffic over a small pc set, so BTB hits, aliasing and collisions all occur.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc, upc;
      pc  = (32'($urandom_range(0, 3)) << (BI + 2)) | (32'($urandom_range(0, 31)) << 2);
      upc = (32'($urandom_range(0, 3)) << (BI + 2)) | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FF00 | (32'($urandom_range(0, 63)) << 2);
      cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) == 0, upc,
          int'($urandom_range(0, HMASK)), $urandom_range(0, 1) == 1,
          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
